// File: rtl/pipe_stage_buffer.sv
// Pipeline register between two stages with stall hold and multi-cycle flush bubbles.
// Optional stall/bubble statistics counters are built when PIPE_STAGE_BUFFER_STATS_EN is defined.
module pipe_stage_buffer #(
  parameter int CTRL_W    = 16,
  parameter int DATA_W    = 52,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              flushing
`ifdef PIPE_STAGE_BUFFER_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       bubble_count
`endif
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

  logic [0:0]        state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Priority: flush, then the flush countdown, then stall, then a normal load.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    if (flush) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = CNT_INIT;
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end else if (state_q == ST_FLUSH) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
      if (flush_cnt_q == 4'd0) begin
        state_d = ST_RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - 4'd1;
      end
    end else if (!stall) begin
      out_valid_d = in_valid;
      out_ctrl_d  = in_valid ? in_ctrl : '0;
      out_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  // Decoded from the state flop only, so no input reaches this output combinationally.
  assign flushing  = (state_q == ST_FLUSH);

`ifdef PIPE_STAGE_BUFFER_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] bubble_count_q, bubble_count_d;
  logic        stall_hit, bubble_hit;

  // A flush edge taken while already in FLUSH counts as a single bubble edge.
  assign stall_hit  = (state_q == ST_RUN) && stall && !flush;
  assign bubble_hit = flush || (state_q == ST_FLUSH);

  always_comb begin
    stall_count_d  = stall_count_q;
    bubble_count_d = bubble_count_q;
    if (stall_hit && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    if (bubble_hit && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q  <= 16'd0;
      bubble_count_q <= 16'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule
